// File: rtl/tlul_pkg.sv
// Minimal TL-UL type set for the peripheral crossbar device ports.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_timer_pkg.sv
// Register map, reset constants and address decode for the machine timer.
package tlul_timer_pkg;

  // Low address bits decoded by the device; upper bits are resolved by the xbar.
  localparam int unsigned TIMER_ADDR_W = 12;

  localparam logic [TIMER_ADDR_W-1:0] TIMER_CTRL_OFFSET        = 12'h000;
  localparam logic [TIMER_ADDR_W-1:0] TIMER_PRESCALE_OFFSET    = 12'h004;
  localparam logic [TIMER_ADDR_W-1:0] TIMER_MTIME_LO_OFFSET    = 12'h008;
  localparam logic [TIMER_ADDR_W-1:0] TIMER_MTIME_HI_OFFSET    = 12'h00C;
  localparam logic [TIMER_ADDR_W-1:0] TIMER_MTIMECMP_LO_OFFSET = 12'h010;
  localparam logic [TIMER_ADDR_W-1:0] TIMER_MTIMECMP_HI_OFFSET = 12'h014;
  localparam logic [TIMER_ADDR_W-1:0] TIMER_INTR_ENABLE_OFFSET = 12'h018;
  localparam logic [TIMER_ADDR_W-1:0] TIMER_INTR_STATE_OFFSET  = 12'h01C;

  // Compare value out of reach so the interrupt stays quiet after reset.
  localparam logic [63:0] TIMER_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [3:0] {
    REG_CTRL,
    REG_PRESCALE,
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_INTR_ENABLE,
    REG_INTR_STATE,
    REG_NONE
  } timer_reg_e;

  function automatic timer_reg_e timer_decode(input logic [TIMER_ADDR_W-1:0] addr);
    timer_reg_e idx;
    case (addr)
      TIMER_CTRL_OFFSET:        idx = REG_CTRL;
      TIMER_PRESCALE_OFFSET:    idx = REG_PRESCALE;
      TIMER_MTIME_LO_OFFSET:    idx = REG_MTIME_LO;
      TIMER_MTIME_HI_OFFSET:    idx = REG_MTIME_HI;
      TIMER_MTIMECMP_LO_OFFSET: idx = REG_MTIMECMP_LO;
      TIMER_MTIMECMP_HI_OFFSET: idx = REG_MTIMECMP_HI;
      TIMER_INTR_ENABLE_OFFSET: idx = REG_INTR_ENABLE;
      TIMER_INTR_STATE_OFFSET:  idx = REG_INTR_STATE;
      default:                  idx = REG_NONE;
    endcase
    return idx;
  endfunction

  // Byte-lane merge of write data into the current register value.
  function automatic logic [31:0] timer_wmerge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tlul_timer_core.sv
// Prescaler, 64-bit mtime counter with bus-write override, comparator and
// registered timer interrupt.
module tlul_timer_core
  import tlul_timer_pkg::*;
#(
  parameter int unsigned PrescaleWidth = 12,
  parameter logic [7:0]  Step          = 8'd1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [PrescaleWidth-1:0] prescale_i,
  input  logic                     prescale_clr_i,
  input  logic                     mtime_lo_we_i,
  input  logic                     mtime_hi_we_i,
  input  logic [31:0]              mtime_wdata_i,
  input  logic [63:0]              mtimecmp_i,
  input  logic                     intr_en_i,
  output logic [63:0]              mtime_o,
  output logic                     cmp_o,
  output logic                     intr_o
);

  logic [PrescaleWidth-1:0] cnt_q, cnt_d;
  logic [63:0]              mtime_q, mtime_d;
  logic                     intr_q, intr_d;
  logic                     tick;

  // Prescale counter: wraps at PRESCALE, frozen while disabled, cleared on reprogramming.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (en_i && (cnt_q == prescale_i)) tick = 1'b1;
    if (prescale_clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // mtime next state: a bus write to one half overrides the tick for the whole word.
  always_comb begin
    mtime_d = mtime_q;
    if (tick) mtime_d = mtime_q + 64'(Step);
    if (mtime_lo_we_i) mtime_d = {mtime_q[63:32], mtime_wdata_i};
    if (mtime_hi_we_i) mtime_d = {mtime_wdata_i, mtime_q[31:0]};
  end

  assign cmp_o  = (mtime_q >= mtimecmp_i);
  assign intr_d = intr_en_i & cmp_o;

  // Counter, mtime and interrupt state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      mtime_q <= '0;
      intr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mtime_q <= mtime_d;
      intr_q  <= intr_d;
    end
  end

  assign mtime_o = mtime_q;
  assign intr_o  = intr_q;

endmodule

// File: rtl/tlul_timer.sv
// RISC-V machine timer device on the TL-UL peripheral crossbar: TL-UL front
// end, address decode and register file around tlul_timer_core.
module tlul_timer
  import tlul_pkg::*;
  import tlul_timer_pkg::*;
#(
  parameter int unsigned PrescaleWidth = 12,
  parameter logic [7:0]  Step          = 8'd1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o,
  output logic    intr_timer_o
);

  logic                     ctrl_en_q, ctrl_en_d;
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic [63:0]              mtimecmp_q, mtimecmp_d;
  logic                     intr_en_q, intr_en_d;

  logic                     d_valid_q, d_valid_d;
  tl_d_op_e                 d_opcode_q, d_opcode_d;
  logic [1:0]               d_size_q, d_size_d;
  logic [7:0]               d_source_q, d_source_d;
  logic [31:0]              d_data_q, d_data_d;
  logic                     d_error_q, d_error_d;

  logic                     a_ready, accept, is_get, is_put, req_err, wr_en;
  timer_reg_e               reg_idx;
  logic [31:0]              reg_rdata, wr_data;
  logic [63:0]              mtime;
  logic                     cmp;
  logic                     unused_tl;

  assign a_ready = ~d_valid_q;
  assign accept  = tl_i.a_valid & a_ready;
  assign reg_idx = timer_decode(tl_i.a_address[TIMER_ADDR_W-1:0]);
  assign is_get  = (tl_i.a_opcode == Get);
  assign is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:TIMER_ADDR_W]};

  // Request classification: misaligned, unmapped, read-only target or unknown opcode.
  always_comb begin
    req_err = 1'b0;
    if (tl_i.a_address[1:0] != 2'b00) req_err = 1'b1;
    if (reg_idx == REG_NONE) req_err = 1'b1;
    if (is_put && (reg_idx == REG_INTR_STATE)) req_err = 1'b1;
    if (!(is_get || is_put)) req_err = 1'b1;
  end

  assign wr_en = accept & is_put & ~req_err;

  // Current value of the addressed register, also the base for byte-masked writes.
  always_comb begin
    reg_rdata = '0;
    case (reg_idx)
      REG_CTRL:        reg_rdata = {31'd0, ctrl_en_q};
      REG_PRESCALE:    reg_rdata = 32'(prescale_q);
      REG_MTIME_LO:    reg_rdata = mtime[31:0];
      REG_MTIME_HI:    reg_rdata = mtime[63:32];
      REG_MTIMECMP_LO: reg_rdata = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: reg_rdata = mtimecmp_q[63:32];
      REG_INTR_ENABLE: reg_rdata = {31'd0, intr_en_q};
      REG_INTR_STATE:  reg_rdata = {31'd0, cmp};
      default:         reg_rdata = '0;
    endcase
  end

  assign wr_data = timer_wmerge(reg_rdata, tl_i.a_data, tl_i.a_mask);

  // Register-file next state from accepted, error-free writes.
  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    prescale_d = prescale_q;
    mtimecmp_d = mtimecmp_q;
    intr_en_d  = intr_en_q;
    if (wr_en) begin
      case (reg_idx)
        REG_CTRL:        ctrl_en_d        = wr_data[0];
        REG_PRESCALE:    prescale_d       = wr_data[PrescaleWidth-1:0];
        REG_MTIMECMP_LO: mtimecmp_d[31:0]  = wr_data;
        REG_MTIMECMP_HI: mtimecmp_d[63:32] = wr_data;
        REG_INTR_ENABLE: intr_en_d        = wr_data[0];
        default: ;
      endcase
    end
  end

  // Register file state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en_q  <= 1'b0;
      prescale_q <= '0;
      mtimecmp_q <= TIMER_MTIMECMP_RST;
      intr_en_q  <= 1'b0;
    end else begin
      ctrl_en_q  <= ctrl_en_d;
      prescale_q <= prescale_d;
      mtimecmp_q <= mtimecmp_d;
      intr_en_q  <= intr_en_d;
    end
  end

  // Response channel: capture on accept, hold until the host takes it.
  always_comb begin
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    d_error_d  = d_error_q;
    if (accept) begin
      d_valid_d  = 1'b1;
      d_opcode_d = is_get ? AccessAckData : AccessAck;
      d_size_d   = tl_i.a_size;
      d_source_d = tl_i.a_source;
      d_data_d   = (is_get && !req_err) ? reg_rdata : 32'd0;
      d_error_d  = req_err;
    end else if (d_valid_q && tl_i.d_ready) begin
      d_valid_d  = 1'b0;
    end
  end

  // Response channel state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= AccessAck;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else begin
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
      d_error_q  <= d_error_d;
    end
  end

  // Drive the TL-UL response bundle.
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid_q;
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = a_ready;
  end

  tlul_timer_core #(
    .PrescaleWidth(PrescaleWidth),
    .Step         (Step)
  ) u_core (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (ctrl_en_q),
    .prescale_i    (prescale_q),
    .prescale_clr_i(wr_en && (reg_idx == REG_PRESCALE)),
    .mtime_lo_we_i (wr_en && (reg_idx == REG_MTIME_LO)),
    .mtime_hi_we_i (wr_en && (reg_idx == REG_MTIME_HI)),
    .mtime_wdata_i (wr_data),
    .mtimecmp_i    (mtimecmp_q),
    .intr_en_i     (intr_en_q),
    .mtime_o       (mtime),
    .cmp_o         (cmp),
    .intr_o        (intr_timer_o)
  );

endmodule

// File: tb/tb_tlul_timer.sv
// Directed and randomized bench for tlul_timer with an arithmetic mtime model.
module tb_tlul_timer;
  import tlul_pkg::*;

  localparam logic [63:0] STEP = 64'd1;
  localparam logic [11:0] A_CTRL = 12'h000, A_PRE = 12'h004, A_LO = 12'h008, A_HI = 12'h00C;
  localparam logic [11:0] A_CLO = 12'h010, A_CHI = 12'h014, A_IE = 12'h018, A_IS = 12'h01C;

  logic        clk = 1'b0;
  logic        rst_n;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o;
  logic        intr;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] r_data;
  logic        r_err;
  logic        r_intr;
  int unsigned r_acc;

  tlul_timer #(.PrescaleWidth(12), .Step(8'd1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i), .tl_o(tl_o), .intr_timer_o(intr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of ticks in cycles a+1..last with counter starting at 0 when enabled in cycle a.
  function automatic logic [63:0] ticks(input int unsigned a, input int unsigned last,
                                        input int unsigned p);
    return 64'((last - a) / (p + 1));
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // One TL-UL transaction; hold = cycles d_ready is kept low after the response appears.
  task automatic xact(input tl_a_op_e op, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input int hold);
    logic [7:0] src;
    int         n;
    src = 8'($urandom);
    @(negedge clk);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_address = {20'h40001, addr};
    tl_i.a_data    = data;
    tl_i.a_mask    = mask;
    tl_i.a_size    = 2'd2;
    tl_i.a_source  = src;
    tl_i.d_ready   = (hold == 0);
    n = 0;
    while (!tl_o.a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_bound", (n < 20), 1'b1);
    r_acc = cyc;
    @(posedge clk);
    #1 tl_i.a_valid = 1'b0;
    @(negedge clk);
    chk("d_valid", tl_o.d_valid, 1'b1);
    chk("d_opcode", tl_o.d_opcode, (op == Get) ? AccessAckData : AccessAck);
    chk("d_source", tl_o.d_source, src);
    r_data = tl_o.d_data;
    r_err  = tl_o.d_error;
    r_intr = intr;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", tl_o.d_valid, 1'b1);
      chk("hold_data", tl_o.d_data, r_data);
      chk("hold_fields", {tl_o.d_error, tl_o.d_source, tl_o.d_size}, {r_err, src, 2'd2});
      chk("hold_a_ready", tl_o.a_ready, 1'b0);
    end
    tl_i.d_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    xact(PutFullData, addr, data, 4'hF, 0);
    chk("wr_err", r_err, 1'b0);
  endtask

  task automatic rd(input logic [11:0] addr);
    xact(Get, addr, 32'd0, 4'hF, 0);
  endtask

  initial begin
    logic [63:0] base, m, cmpm;
    int unsigned a, b, w, p, first;
    logic [31:0] v0, pd;
    logic [3:0]  pm;

    rst_n = 1'b0;
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_d_valid", tl_o.d_valid, 1'b0);
    chk("rst_a_ready", tl_o.a_ready, 1'b1);
    chk("rst_intr", intr, 1'b0);
    chk("rst_d_fields", {tl_o.d_data, tl_o.d_error, tl_o.d_source, tl_o.d_opcode}, '0);
    rst_n = 1'b1;

    // Reset values of every register
    rd(A_CTRL); chk("rst_ctrl", r_data, 32'd0);
    rd(A_PRE);  chk("rst_prescale", r_data, 32'd0);
    rd(A_LO);   chk("rst_mtime_lo", r_data, 32'd0);
    rd(A_HI);   chk("rst_mtime_hi", r_data, 32'd0);
    rd(A_CLO);  chk("rst_cmp_lo", r_data, 32'hFFFF_FFFF);
    rd(A_CHI);  chk("rst_cmp_hi", r_data, 32'hFFFF_FFFF);
    rd(A_IE);   chk("rst_ie", r_data, 32'd0);
    rd(A_IS);   chk("rst_is", r_data, 32'd0);

    // Tick rate with PRESCALE=3, then freeze
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'd1); a = r_acc;
    repeat (40) @(negedge clk);
    rd(A_LO);
    chk("tick_rate_lo", r_data, 32'(ticks(a, r_acc - 1, 3) * STEP));
    wr(A_CTRL, 32'd0); b = r_acc;
    m = ticks(a, b, 3) * STEP;
    rd(A_LO); chk("frozen_lo_0", r_data, m[31:0]);
    repeat (20) @(negedge clk);
    rd(A_LO); chk("frozen_lo_1", r_data, m[31:0]);

    // Interrupt rise and drop timing
    wr(A_PRE, 32'd0);
    wr(A_LO, 32'd0);
    wr(A_HI, 32'd0);
    wr(A_CLO, 32'd20);
    wr(A_CHI, 32'd0);
    wr(A_IE, 32'd1);
    wr(A_CTRL, 32'd1); a = r_acc;
    first = 0;
    for (int k = 0; k < 40 && first == 0; k++) begin
      @(negedge clk);
      if (intr === 1'b1) first = cyc;
    end
    chk("intr_rise_cycle", first, a + 22);
    rd(A_IS); chk("intr_state_set", r_data, 32'd1);
    wr(A_CLO, 32'd100);
    chk("intr_held_after_cmp_write", r_intr, 1'b1);
    @(negedge clk);
    chk("intr_dropped", intr, 1'b0);
    wr(A_CTRL, 32'd0);
    wr(A_IE, 32'd0);

    // Wrap-around through 2^64
    wr(A_PRE, 32'd0);
    wr(A_HI, 32'hFFFF_FFFF);
    wr(A_LO, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'd1); a = r_acc;
    wr(A_CTRL, 32'd0); b = r_acc;
    m = 64'hFFFF_FFFF_FFFF_FFFE + ticks(a, b, 0) * STEP;
    rd(A_HI); chk("wrap_hi", r_data, m[63:32]);
    rd(A_LO); chk("wrap_lo", r_data, m[31:0]);
    rd(A_IS); chk("wrap_is", r_data, 32'({m >= 64'd100}));

    // Bus write to MTIME_LO in a tick cycle wins over the increment
    wr(A_PRE, 32'd3);
    wr(A_HI, 32'd0);
    wr(A_LO, 32'd0);
    wr(A_CTRL, 32'd1); a = r_acc;
    do begin @(posedge clk); #1; end while (((cyc - a - 1) % 4) != 3);
    w = cyc;
    wr(A_LO, 32'h55);
    chk("prec_write_cycle", r_acc, w);
    rd(A_LO); chk("prec_lo", r_data, 32'h55 + 32'(ticks(a, r_acc - 1, 3) - ticks(a, w, 3)));
    wr(A_CTRL, 32'd0);

    // Byte-masked writes
    wr(A_LO, 32'hAABB_CCDD);
    xact(PutPartialData, A_LO, 32'h1122_3344, 4'b0001, 0);
    chk("partial_err", r_err, 1'b0);
    rd(A_LO); chk("partial_lo", r_data, 32'hAABB_CC44);
    xact(PutPartialData, A_PRE, 32'h0000_0A00, 4'b0010, 0);
    rd(A_PRE); chk("partial_prescale", r_data, 32'h0000_0A03);

    // Error responses
    rd(12'h040);
    chk("unmapped_err", r_err, 1'b1);
    chk("unmapped_data", r_data, 32'd0);
    rd(12'h00A);
    chk("misaligned_err", r_err, 1'b1);
    chk("misaligned_data", r_data, 32'd0);
    rd(A_IS); v0 = r_data;
    chk("is_before", v0, 32'({{32'hAABB_CC44} >= 64'd100}));
    xact(PutFullData, A_IS, 32'h0, 4'hF, 0);
    chk("is_write_err", r_err, 1'b1);
    rd(A_IS); chk("is_unchanged", r_data, v0);
    xact(PutFullData, 12'h020, 32'h1, 4'hF, 0);
    chk("unmapped_write_err", r_err, 1'b1);

    // Backpressure: response held for 5 cycles
    xact(Get, A_CLO, 32'd0, 4'hF, 5);
    chk("bp_data", r_data, 32'd100);

    // Randomized runs against the arithmetic model
    cmpm = {32'd0, 32'd100};
    for (int it = 0; it < 6; it++) begin
      p = $urandom_range(0, 5);
      base[63:32] = $urandom;
      base[31:0]  = (it % 2 == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 30) : $urandom;
      wr(A_PRE, p);
      wr(A_LO, base[31:0]);
      wr(A_HI, base[63:32]);
      wr(A_CTRL, 32'd1); a = r_acc;
      repeat ($urandom_range(0, 30)) @(negedge clk);
      rd(A_LO);
      m = base + ticks(a, r_acc - 1, p) * STEP;
      chk("rnd_lo", r_data, m[31:0]);
      rd(A_HI);
      m = base + ticks(a, r_acc - 1, p) * STEP;
      chk("rnd_hi", r_data, m[63:32]);
      wr(A_CTRL, 32'd0); b = r_acc;
      m = base + ticks(a, b, p) * STEP;
      repeat ($urandom_range(1, 10)) @(negedge clk);
      rd(A_LO); chk("rnd_frozen_lo", r_data, m[31:0]);
      pd = $urandom;
      pm = 4'($urandom);
      xact(PutPartialData, A_CHI, pd, pm, 0);
      cmpm[63:32] = bmerge(cmpm[63:32], pd, pm);
      rd(A_CHI); chk("rnd_cmp_hi", r_data, cmpm[63:32]);
      rd(A_IS); chk("rnd_is", r_data, 32'({m >= cmpm}));
    end

    // Asynchronous reset with a response pending
    wr(A_CHI, 32'd0);
    wr(A_CLO, 32'd0);
    wr(A_IE, 32'd1);
    @(negedge clk);
    chk("pre_rst_intr", intr, 1'b1);
    tl_i.a_valid = 1'b1; tl_i.a_opcode = Get; tl_i.a_address = 32'h4000_1000;
    tl_i.d_ready = 1'b0;
    @(posedge clk);
    #1 tl_i.a_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_d_valid", tl_o.d_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d_valid", tl_o.d_valid, 1'b0);
    chk("arst_a_ready", tl_o.a_ready, 1'b1);
    chk("arst_intr", intr, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tl_i.d_ready = 1'b1;
    rd(A_CLO); chk("arst_cmp_lo", r_data, 32'hFFFF_FFFF);
    rd(A_IE);  chk("arst_ie", r_data, 32'd0);
    rd(A_PRE); chk("arst_prescale", r_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
